multicycle_control_fsm: RTL
===========================

Name: multicycle_control_fsm

Overview:
- Sequencing controller for the multi-cycle version of the MIPS datapath: one shared memory, instruction register, ALU reused for PC increment and branch target.
- Replaces the combinational single-cycle controller. Walks each instruction through fetch, decode, execute, memory and writeback states.
- Drives every datapath mux select and write enable, and waits on a memory ready handshake.

Parameters:
- OP_RTYPE, 6'b000000, R-type opcode
- OP_LW, 6'b100011, load word opcode
- OP_SW, 6'b101011, store word opcode
- OP_BEQ, 6'b000100, branch-equal opcode
- OP_J, 6'b000010, jump opcode
- OP_ADDI, 6'b001000, add-immediate opcode

Ports:
- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  synchronous reset, active-high
- opcode  in  6  IR[31:26]; stable from DECODE onward (IR held)
- mem_ready  in  1  memory completes the current read/write this cycle
- PCWrite  out  1  unconditional PC load
- PCWriteCond  out  1  PC load qualified by ALU zero (beq)
- IorD  out  1  memory address select: 0=PC, 1=ALUOut
- MemRead  out  1  memory read request
- MemWrite  out  1  memory write request
- IRWrite  out  1  instruction register load
- MemtoReg  out  1  register write data: 0=ALUOut, 1=MDR
- RegDst  out  1  write register: 0=rt, 1=rd
- RegWrite  out  1  register file write enable
- ALUSrcA  out  1  ALU A: 0=PC, 1=reg A
- ALUSrcB  out  2  ALU B: 00=reg B, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2
- ALUOp  out  2  to the ALU control block: 00=add, 01=sub, 10=funct
- PCSource  out  2  PC input: 00=ALU result, 01=ALUOut, 10=jump target
- instr_done  out  1  one-cycle pulse in an instruction's final cycle
- illegal_op  out  1  one-cycle pulse in DECODE on an unknown opcode
- state_out  out  4  current state encoding (debug)

Behaviour:
- State encodings: FETCH=0, DECODE=1, MEMADDR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTE=6, RTYPE_WB=7, BRANCH=8, JUMP=9, ADDI_EX=10, ADDI_WB=11. Codes 12-15 are unreachable and go to FETCH.
- Reset: rst sampled high puts the state in FETCH at the edge. While rst=1, PCWrite, PCWriteCond, IRWrite, MemRead, MemWrite, RegWrite, instr_done and illegal_op are forced 0 combinationally.
- Reset mid-instruction aborts it with no partial writes after the reset edge.
- Outputs are combinational decodes of the state, plus mem_ready where noted. Any output not listed for a state is 0.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00; IRWrite=PCWrite=mem_ready. Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (precomputes branch target).
  - lw/sw -> MEMADDR; R-type -> EXECUTE; beq -> BRANCH; j -> JUMP; addi -> ADDI_EX.
  - Any other opcode: illegal_op=1, next state FETCH.
- MEMADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. lw -> MEMREAD, sw -> MEMWRITE.
- MEMREAD: MemRead=1, IorD=1. Holds until mem_ready, then -> MEMWB.
- MEMWB: RegWrite=1, MemtoReg=1, RegDst=0, instr_done=1. -> FETCH.
- MEMWRITE: MemWrite=1, IorD=1. Holds until mem_ready. instr_done=mem_ready; -> FETCH on mem_ready.
- EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUOp=10. -> RTYPE_WB.
- RTYPE_WB: RegWrite=1, RegDst=1, MemtoReg=0, instr_done=1. -> FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01, instr_done=1. -> FETCH.
- JUMP: PCWrite=1, PCSource=10, instr_done=1. -> FETCH.
- ADDI_EX: ALUSrcA=1, ALUSrcB=10, ALUOp=00. -> ADDI_WB.
- ADDI_WB: RegWrite=1, RegDst=0, MemtoReg=0, instr_done=1. -> FETCH.
- Latency with mem_ready tied high:
  - lw = 5 cycles
  - sw, R-type, addi = 4 cycles
  - beq, j = 3 cycles
  - Each cycle mem_ready is low in FETCH, MEMREAD or MEMWRITE adds one cycle.
- mem_ready is ignored in every state other than FETCH, MEMREAD and MEMWRITE.
- MemRead and MemWrite are never high in the same cycle.
- opcode is sampled only in DECODE and MEMADDR.

Test Plan:
- Reset, then rst=0 with mem_ready=1 and opcode=R-type -> state_out 0,1,6,7,0. RegWrite=1 and RegDst=1 only in the 4th cycle; instr_done pulses once.
- lw with mem_ready low 2 cycles in FETCH and 3 cycles in MEMREAD -> 10 cycles total. IRWrite and PCWrite high exactly once; RegWrite with MemtoReg=1 exactly once.
- sw with mem_ready=1 -> states 0,1,2,5,0. MemWrite=1 with IorD=1 for 1 cycle; RegWrite never asserted.
- beq then j back-to-back -> BRANCH cycle has PCWriteCond=1, PCSource=01, ALUOp=01. JUMP cycle has PCWrite=1, PCSource=10. Each takes 3 cycles.
- opcode=6'b111111 -> illegal_op pulses in the DECODE cycle; next state FETCH; no RegWrite or MemWrite.
- rst asserted in MEMREAD while mem_ready=0 -> all enables 0 that cycle, state_out=0 next cycle, no RegWrite for the aborted load.

Source files
------------

// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm: sequences the multi-cycle MIPS datapath through fetch/decode/execute/memory/writeback.
module multicycle_control_fsm #(
    parameter logic [5:0] OP_RTYPE = 6'b000000,
    parameter logic [5:0] OP_LW    = 6'b100011,
    parameter logic [5:0] OP_SW    = 6'b101011,
    parameter logic [5:0] OP_BEQ   = 6'b000100,
    parameter logic [5:0] OP_J     = 6'b000010,
    parameter logic [5:0] OP_ADDI  = 6'b001000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSource,
    output logic       instr_done,
    output logic       illegal_op,
    output logic [3:0] state_out
);
    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADDR  = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTE  = 4'd6,
        RTYPE_WB = 4'd7,
        BRANCH   = 4'd8,
        JUMP     = 4'd9,
        ADDI_EX  = 4'd10,
        ADDI_WB  = 4'd11
    } state_t;

    state_t state, next;

    always_ff @(posedge clk)
        state <= rst ? FETCH : next;

    assign state_out = state;

    always_comb begin
        next        = FETCH;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ALUOp       = 2'b00;
        PCSource    = 2'b00;
        instr_done  = 1'b0;
        illegal_op  = 1'b0;
        case (state)
            FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
                next    = mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                ALUSrcB = 2'b11;
                case (opcode)
                    OP_LW, OP_SW: next = MEMADDR;
                    OP_RTYPE:     next = EXECUTE;
                    OP_BEQ:       next = BRANCH;
                    OP_J:         next = JUMP;
                    OP_ADDI:      next = ADDI_EX;
                    default:      illegal_op = 1'b1;
                endcase
            end
            MEMADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                next    = (opcode == OP_SW) ? MEMWRITE : MEMREAD;
            end
            MEMREAD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                next    = mem_ready ? MEMWB : MEMREAD;
            end
            MEMWB: begin
                RegWrite   = 1'b1;
                MemtoReg   = 1'b1;
                instr_done = 1'b1;
            end
            MEMWRITE: begin
                MemWrite   = 1'b1;
                IorD       = 1'b1;
                instr_done = mem_ready;
                next       = mem_ready ? FETCH : MEMWRITE;
            end
            EXECUTE: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
                next    = RTYPE_WB;
            end
            RTYPE_WB: begin
                RegWrite   = 1'b1;
                RegDst     = 1'b1;
                instr_done = 1'b1;
            end
            BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = 2'b01;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
                instr_done  = 1'b1;
            end
            JUMP: begin
                PCWrite    = 1'b1;
                PCSource   = 2'b10;
                instr_done = 1'b1;
            end
            ADDI_EX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                next    = ADDI_WB;
            end
            ADDI_WB: begin
                RegWrite   = 1'b1;
                instr_done = 1'b1;
            end
            default: next = FETCH;
        endcase
        // Reset must suppress every side effect of the aborted instruction in the same cycle.
        if (rst) begin
            PCWrite     = 1'b0;
            PCWriteCond = 1'b0;
            IRWrite     = 1'b0;
            MemRead     = 1'b0;
            MemWrite    = 1'b0;
            RegWrite    = 1'b0;
            instr_done  = 1'b0;
            illegal_op  = 1'b0;
        end
    end
endmodule
